// File: rtl/ex_pkg.sv
// ex_pkg: shared opcodes, multiply FSM states, EX/MEM record and forwarding helper
package ex_pkg;
  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_FUNCT = 2'b10;
  localparam logic [1:0] OP_OR    = 2'b11;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_MUL = 6'b011000;
  localparam int MUL_ITERS = 32;
  localparam int CNT_W = $clog2(MUL_ITERS);
  typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_e;
  typedef struct packed {
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic [4:0]  wb_addr;
    logic [31:0] write_data;
    logic [31:0] result;
  } exmem_t;
  // EX/MEM wins over MEM/WB; register 0 is hardwired and never forwarded
  function automatic logic [31:0] fwd(
    input logic [4:0] addr, input logic [31:0] data,
    input logic ex_we, input logic [4:0] ex_rd, input logic [31:0] ex_d,
    input logic wb_we, input logic [4:0] wb_rd, input logic [31:0] wb_d);
    return (ex_we && ex_rd != 5'd0 && ex_rd == addr) ? ex_d :
           (wb_we && wb_rd != 5'd0 && wb_rd == addr) ? wb_d : data;
  endfunction
endpackage

// File: rtl/iter_mul32.sv
// iter_mul32: shift-and-add multiplier, one partial product per cycle, low 32 bits kept
module iter_mul32
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);
  mul_state_e state, state_nx;
  logic [31:0] acc, mcand, mplier;
  logic [CNT_W-1:0] count;
  // state register
  always_ff @(posedge clk)
    state <= rst ? MUL_IDLE : state_nx;
  // next state: start only honoured in IDLE, DONE always returns to IDLE
  always_comb
    state_nx = state == MUL_IDLE ? (start ? MUL_BUSY : MUL_IDLE) :
               state == MUL_BUSY ? (count == CNT_W'(MUL_ITERS - 1) ? MUL_DONE : MUL_BUSY) :
               MUL_IDLE;
  // outputs decoded from state
  always_comb begin
    busy = state == MUL_BUSY;
    done = state == MUL_DONE;
    product = acc;
  end
  // datapath: capture operands once, then one add/shift per BUSY cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      count <= '0;
    end else if (state == MUL_IDLE && start) begin
      acc <= '0;
      mcand <= a;
      mplier <= b;
      count <= '0;
    end else if (state == MUL_BUSY) begin
      acc <= mplier[0] ? acc + mcand : acc;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      count <= count + CNT_W'(1);
    end
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: forwarding, ALU and EX/MEM register; EX_ITER_MUL_EN adds the iterative multiplier
module ex_stage
  import ex_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        RegDst_i,
  input  logic        ALUSrc_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        MemtoReg_i,
  input  logic        RegWrite_i,
  input  logic [1:0]  ALUOp_i,
  input  logic [31:0] RSdata_i,
  input  logic [31:0] RTdata_i,
  input  logic [31:0] immediate_i,
  input  logic [4:0]  RSaddr_i,
  input  logic [4:0]  RTaddr_i,
  input  logic [4:0]  RDaddr_i,
  input  logic        EXMEM_RegWrite_i,
  input  logic [4:0]  EXMEM_RDaddr_i,
  input  logic [31:0] EXMEM_data_i,
  input  logic        MEMWB_RegWrite_i,
  input  logic [4:0]  MEMWB_RDaddr_i,
  input  logic [31:0] MEMWB_data_i,
  output logic        stall_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic        MemtoReg_o,
  output logic        RegWrite_o,
  output logic [31:0] ALUresult_o,
  output logic [31:0] WriteData_o,
  output logic [4:0]  WBaddr_o
);
  logic [31:0] a, rt_fwd, b, alu;
  logic [5:0] funct;
  logic bubble, done;
  exmem_t cur, done_val, q;
  // operand selection with forwarding
  always_comb begin
    a = fwd(RSaddr_i, RSdata_i, EXMEM_RegWrite_i, EXMEM_RDaddr_i, EXMEM_data_i,
            MEMWB_RegWrite_i, MEMWB_RDaddr_i, MEMWB_data_i);
    rt_fwd = fwd(RTaddr_i, RTdata_i, EXMEM_RegWrite_i, EXMEM_RDaddr_i, EXMEM_data_i,
                 MEMWB_RegWrite_i, MEMWB_RDaddr_i, MEMWB_data_i);
    b = ALUSrc_i ? immediate_i : rt_fwd;
    funct = immediate_i[5:0];
  end
  // ALU; unknown funct (including mul when the multiplier is absent) yields 0
  always_comb
    alu = ALUOp_i == OP_ADD ? a + b :
          ALUOp_i == OP_SUB ? a - b :
          ALUOp_i == OP_OR  ? a | b :
          funct == F_ADD ? a + b :
          funct == F_SUB ? a - b :
          funct == F_AND ? a & b :
          funct == F_OR  ? a | b :
          funct == F_SLT ? {31'd0, $signed(a) < $signed(b)} : 32'd0;
  // record that EX/MEM loads for an ordinary instruction
  always_comb
    cur = '{MemRead_i, MemWrite_i, MemtoReg_i, RegWrite_i,
            RegDst_i ? RDaddr_i : RTaddr_i, rt_fwd, alu};
`ifdef EX_ITER_MUL_EN
  logic is_mul, start, busy;
  logic [31:0] product;
  exmem_t lat;
  // DONE is excluded so the finished mul still held in ID/EX does not restart
  always_comb begin
    is_mul = ALUOp_i == OP_FUNCT && funct == F_MUL;
    start = is_mul && !busy && !done;
    bubble = start || busy;
    stall_o = !rst_i && (start || busy);
  end
  iter_mul32 u_mul (
    .clk(clk_i), .rst(rst_i), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );
  // control and destination of the mul, replayed when the product is ready
  always_ff @(posedge clk_i)
    lat <= rst_i ? '0 : start ? cur : lat;
  // product replaces the ALU result in the latched record
  always_comb begin
    done_val = lat;
    done_val.result = product;
  end
`else
  // no multiplier: never stall, never bubble
  always_comb begin
    bubble = 1'b0;
    done = 1'b0;
    stall_o = 1'b0;
    done_val = '0;
  end
`endif
  // EX/MEM pipeline register
  always_ff @(posedge clk_i)
    q <= (rst_i || bubble) ? '0 : done ? done_val : cur;
  // unpack the register onto the output ports
  always_comb begin
    MemRead_o = q.mem_read;
    MemWrite_o = q.mem_write;
    MemtoReg_o = q.mem_to_reg;
    RegWrite_o = q.reg_write;
    WBaddr_o = q.wb_addr;
    WriteData_o = q.write_data;
    ALUresult_o = q.result;
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed checks of forwarding, ALU, EX/MEM timing and (if EX_ITER_MUL_EN) the multiplier
module tb_ex_stage;
  logic clk_i = 1'b0, rst_i;
  logic RegDst_i, ALUSrc_i, MemRead_i, MemWrite_i, MemtoReg_i, RegWrite_i;
  logic [1:0] ALUOp_i;
  logic [31:0] RSdata_i, RTdata_i, immediate_i;
  logic [4:0] RSaddr_i, RTaddr_i, RDaddr_i;
  logic EXMEM_RegWrite_i, MEMWB_RegWrite_i;
  logic [4:0] EXMEM_RDaddr_i, MEMWB_RDaddr_i;
  logic [31:0] EXMEM_data_i, MEMWB_data_i;
  logic stall_o, MemRead_o, MemWrite_o, MemtoReg_o, RegWrite_o;
  logic [31:0] ALUresult_o, WriteData_o;
  logic [4:0] WBaddr_o;
  int errors = 0, checks = 0;

  ex_stage dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .RegDst_i(RegDst_i), .ALUSrc_i(ALUSrc_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .MemtoReg_i(MemtoReg_i), .RegWrite_i(RegWrite_i), .ALUOp_i(ALUOp_i),
    .RSdata_i(RSdata_i), .RTdata_i(RTdata_i), .immediate_i(immediate_i),
    .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i),
    .EXMEM_RegWrite_i(EXMEM_RegWrite_i), .EXMEM_RDaddr_i(EXMEM_RDaddr_i), .EXMEM_data_i(EXMEM_data_i),
    .MEMWB_RegWrite_i(MEMWB_RegWrite_i), .MEMWB_RDaddr_i(MEMWB_RDaddr_i), .MEMWB_data_i(MEMWB_data_i),
    .stall_o(stall_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .MemtoReg_o(MemtoReg_o),
    .RegWrite_o(RegWrite_o), .ALUresult_o(ALUresult_o), .WriteData_o(WriteData_o), .WBaddr_o(WBaddr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic instr(input logic [1:0] op, input logic [31:0] imm, input logic src,
                       input logic [31:0] rs, input logic [31:0] rt);
    ALUOp_i = op;
    immediate_i = imm;
    ALUSrc_i = src;
    RSdata_i = rs;
    RTdata_i = rt;
  endtask

  task automatic defaults();
    RegDst_i = 1'b1; MemRead_i = 1'b0; MemWrite_i = 1'b0; MemtoReg_i = 1'b0; RegWrite_i = 1'b1;
    RSaddr_i = 5'd1; RTaddr_i = 5'd2; RDaddr_i = 5'd3;
    EXMEM_RegWrite_i = 1'b0; EXMEM_RDaddr_i = 5'd0; EXMEM_data_i = 32'd0;
    MEMWB_RegWrite_i = 1'b0; MEMWB_RDaddr_i = 5'd0; MEMWB_data_i = 32'd0;
    instr(2'b00, 32'd0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_res"}, ALUresult_o, 32'd0);
    chk({tag, "_ctl"}, {28'd0, MemRead_o, MemWrite_o, MemtoReg_o, RegWrite_o}, 32'd0);
    chk({tag, "_wd"}, WriteData_o, 32'd0);
    chk({tag, "_wb"}, {27'd0, WBaddr_o}, 32'd0);
  endtask

`ifdef EX_ITER_MUL_EN
  int n, total;
  logic bub_ok;
  // step through stall cycles; returns stall length, flags any non-bubble in EX/MEM
  task automatic run_mul(output int cyc);
    cyc = 0;
    bub_ok = 1'b1;
    while (stall_o && cyc < 40) begin
      step();
      cyc++;
      if (RegWrite_o !== 1'b0 || MemWrite_o !== 1'b0) bub_ok = 1'b0;
      EXMEM_data_i = EXMEM_data_i + 32'h1111;
    end
  endtask
`endif

  initial begin
    defaults();
    rst_i = 1'b1;
    step();
    step();
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk_zero("rst");
    rst_i = 1'b0;

    instr(2'b00, 32'd0, 1'b0, 32'd5, 32'd7);
    step();
    chk("add_res", ALUresult_o, 32'd12);
    chk("add_wb", {27'd0, WBaddr_o}, 32'd3);
    chk("add_rw", {31'd0, RegWrite_o}, 32'd1);
    chk("add_stall", {31'd0, stall_o}, 32'd0);

    RSaddr_i = 5'd4;
    EXMEM_RegWrite_i = 1'b1; EXMEM_RDaddr_i = 5'd4; EXMEM_data_i = 32'd100;
    MEMWB_RegWrite_i = 1'b1; MEMWB_RDaddr_i = 5'd4; MEMWB_data_i = 32'd200;
    instr(2'b00, 32'd0, 1'b0, 32'd1, 32'd1);
    step();
    chk("fwd_exmem", ALUresult_o, 32'd101);
    EXMEM_RegWrite_i = 1'b0;
    step();
    chk("fwd_memwb", ALUresult_o, 32'd201);
    EXMEM_RegWrite_i = 1'b1;
    RSaddr_i = 5'd0; EXMEM_RDaddr_i = 5'd0; MEMWB_RDaddr_i = 5'd0;
    step();
    chk("fwd_zero", ALUresult_o, 32'd2);

    defaults();
    RegDst_i = 1'b0; RegWrite_i = 1'b0; MemWrite_i = 1'b1; RTaddr_i = 5'd6;
    MEMWB_RegWrite_i = 1'b1; MEMWB_RDaddr_i = 5'd6; MEMWB_data_i = 32'd50;
    instr(2'b00, 32'd8, 1'b1, 32'd10, 32'd9);
    step();
    chk("sw_res", ALUresult_o, 32'd18);
    chk("sw_wd", WriteData_o, 32'd50);
    chk("sw_wb", {27'd0, WBaddr_o}, 32'd6);
    chk("sw_ctl", {28'd0, MemRead_o, MemWrite_o, MemtoReg_o, RegWrite_o}, 32'h4);

    defaults();
    instr(2'b10, 32'h2A, 1'b0, 32'hFFFFFFFF, 32'd1);
    step();
    chk("slt", ALUresult_o, 32'd1);
    instr(2'b01, 32'd0, 1'b0, 32'd3, 32'd5);
    step();
    chk("sub", ALUresult_o, 32'hFFFFFFFE);
    instr(2'b10, 32'h24, 1'b0, 32'h0000F0F0, 32'h0000FF00);
    step();
    chk("and", ALUresult_o, 32'h0000F000);
    instr(2'b11, 32'd0, 1'b0, 32'h0000F0F0, 32'h0000FF00);
    step();
    chk("or", ALUresult_o, 32'h0000FFF0);
    instr(2'b10, 32'h3F, 1'b0, 32'd3, 32'd5);
    step();
    chk("bad_funct", ALUresult_o, 32'd0);
    chk("bad_funct_rw", {31'd0, RegWrite_o}, 32'd1);

`ifdef EX_ITER_MUL_EN
    RSaddr_i = 5'd4; EXMEM_RegWrite_i = 1'b1; EXMEM_RDaddr_i = 5'd4; EXMEM_data_i = 32'h00012345;
    instr(2'b10, 32'h18, 1'b0, 32'd0, 32'h00000100);
    #1;
    chk("mul_stall_t", {31'd0, stall_o}, 32'd1);
    run_mul(n);
    chk("mul_stall_len", n, 33);
    chk("mul_bubbles", {31'd0, bub_ok}, 32'd1);
    step();
    chk("mul_res", ALUresult_o, 32'h01234500);
    chk("mul_rw", {31'd0, RegWrite_o}, 32'd1);
    chk("mul_wb", {27'd0, WBaddr_o}, 32'd3);

    defaults();
    instr(2'b10, 32'h18, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    #1;
    run_mul(n);
    step();
    chk("mul_neg", ALUresult_o, 32'd1);

    instr(2'b10, 32'h18, 1'b0, 32'd3, 32'd5);
    #1;
    run_mul(n);
    total = n;
    step();
    total++;
    chk("b2b_res1", ALUresult_o, 32'd15);
    instr(2'b10, 32'h18, 1'b0, 32'd7, 32'd9);
    #1;
    chk("b2b_stall2", {31'd0, stall_o}, 32'd1);
    run_mul(n);
    total += n;
    step();
    total++;
    chk("b2b_res2", ALUresult_o, 32'd63);
    chk("b2b_cycles", total, 68);

    instr(2'b10, 32'h18, 1'b0, 32'd6, 32'd6);
    for (int i = 0; i < 11; i++) step();
    chk("rst_mid_busy", {31'd0, stall_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    chk("rst_mid_force", {31'd0, stall_o}, 32'd0);
    step();
    instr(2'b00, 32'd0, 1'b0, 32'd2, 32'd2);
    rst_i = 1'b0;
    #1;
    chk("rst_mid_stall", {31'd0, stall_o}, 32'd0);
    chk_zero("rst_mid");
    step();
    chk("rst_add", ALUresult_o, 32'd4);
    chk("rst_add_stall", {31'd0, stall_o}, 32'd0);
`else
    instr(2'b10, 32'h18, 1'b0, 32'd3, 32'd5);
    #1;
    chk("nomul_stall", {31'd0, stall_o}, 32'd0);
    step();
    chk("nomul_res", ALUresult_o, 32'd0);
    chk("nomul_rw", {31'd0, RegWrite_o}, 32'd1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk_zero("rst2");
    instr(2'b00, 32'd0, 1'b0, 32'd2, 32'd2);
    step();
    chk("rst_add", ALUresult_o, 32'd4);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
